// File: rtl/crc16_pkg.sv
// Shared CRC-16/CCITT-FALSE definitions used by the frame generator and checker.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD1 = 2'd1,
    ST_HOLD2 = 2'd2
  } hold_state_e;

  // One byte folded in MSB-first, no reflection.
  function automatic logic [15:0] crc16_byte_update(input logic [15:0] crc,
                                                    input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 checker: strips the trailing 2 CRC bytes, forwards the
// payload with a corrected last flag and reports per-frame status and counts.
module crc16_frame_checker
  import crc16_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             status_valid,
  output logic             status_crc_ok,
  output logic             status_short,
  output logic [LEN_W-1:0] status_len,
  output logic [15:0]      status_crc_rx,
  output logic [15:0]      status_crc_calc,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);

  hold_state_e      r_state;
  logic [7:0]       r_older;
  logic [7:0]       r_newer;
  logic [15:0]      r_crc;
  logic [LEN_W-1:0] r_len;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic             r_status_valid;
  logic             r_status_crc_ok;
  logic             r_status_short;
  logic [LEN_W-1:0] r_status_len;
  logic [15:0]      r_status_crc_rx;
  logic [15:0]      r_status_crc_calc;
  logic [CNT_W-1:0] r_ok_count;
  logic [CNT_W-1:0] r_err_count;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_end;
  logic             w_full;
  logic [15:0]      w_crc_next;
  logic [15:0]      w_crc_rx;
  logic [LEN_W-1:0] w_len_next;
  logic             w_frame_ok;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_end      = w_accept && in_last;
  assign w_full     = (r_state == ST_HOLD2);
  assign w_crc_next = crc16_byte_update(r_crc, r_older);
  assign w_crc_rx   = {r_newer, in_data};
  assign w_len_next = (r_len == '1) ? r_len : r_len + LEN_W'(1);
  assign w_frame_ok = w_full && (w_crc_rx == w_crc_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_older           <= 8'h00;
      r_newer           <= 8'h00;
      r_crc             <= CRC16_INIT;
      r_len             <= '0;
      r_out_valid       <= 1'b0;
      r_out_data        <= 8'h00;
      r_out_last        <= 1'b0;
      r_status_valid    <= 1'b0;
      r_status_crc_ok   <= 1'b0;
      r_status_short    <= 1'b0;
      r_status_len      <= '0;
      r_status_crc_rx   <= 16'h0000;
      r_status_crc_calc <= 16'h0000;
      r_ok_count        <= '0;
      r_err_count       <= '0;
    end else begin
      r_status_valid <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            r_older <= in_data;
            r_state <= ST_HOLD1;
          end
          ST_HOLD1: begin
            r_newer <= in_data;
            r_state <= ST_HOLD2;
          end
          default: begin
            // The older byte is now known to be payload, not CRC.
            r_out_valid <= 1'b1;
            r_out_data  <= r_older;
            r_out_last  <= in_last;
            r_crc       <= w_crc_next;
            r_len       <= w_len_next;
            r_older     <= r_newer;
            r_newer     <= in_data;
          end
        endcase
      end

      if (w_end) begin
        r_status_valid    <= 1'b1;
        r_status_crc_ok   <= w_frame_ok;
        r_status_short    <= !w_full;
        r_status_len      <= w_full ? w_len_next : '0;
        r_status_crc_rx   <= w_full ? w_crc_rx : 16'h0000;
        r_status_crc_calc <= w_full ? w_crc_next : CRC16_INIT;
        if (w_frame_ok) begin
          if (r_ok_count != '1) r_ok_count <= r_ok_count + CNT_W'(1);
        end else begin
          if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
        end
        r_crc   <= CRC16_INIT;
        r_len   <= '0;
        r_state <= ST_IDLE;
      end
    end
  end

  assign in_ready        = w_in_ready;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign out_last        = r_out_last;
  assign status_valid    = r_status_valid;
  assign status_crc_ok   = r_status_crc_ok;
  assign status_short    = r_status_short;
  assign status_len      = r_status_len;
  assign status_crc_rx   = r_status_crc_rx;
  assign status_crc_calc = r_status_crc_calc;
  assign ok_count        = r_ok_count;
  assign err_count       = r_err_count;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Randomized bench for crc16_frame_checker against a bit-serial frame-level reference model.
module tb_crc16_frame_checker;

  localparam int LEN_W = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             status_valid;
  logic             status_crc_ok;
  logic             status_short;
  logic [LEN_W-1:0] status_len;
  logic [15:0]      status_crc_rx;
  logic [15:0]      status_crc_calc;
  logic [CNT_W-1:0] ok_count;
  logic [CNT_W-1:0] err_count;

  crc16_frame_checker #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .status_valid(status_valid), .status_crc_ok(status_crc_ok), .status_short(status_short),
    .status_len(status_len), .status_crc_rx(status_crc_rx), .status_crc_calc(status_crc_calc),
    .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  typedef struct { logic [7:0] d; logic last; } pay_t;
  typedef struct {
    logic ok; logic sh; logic [15:0] len; logic [15:0] rx; logic [15:0] calc;
    logic [15:0] okc; logic [15:0] errc;
  } st_t;

  pay_t       exp_pay[$];
  st_t        exp_st[$];
  logic [7:0] frm[$];
  int         m_ok  = 0;
  int         m_err = 0;
  bit         rdy_mode = 1'b0;

  // Reference CRC: one message bit at a time through the LFSR feedback.
  function automatic logic [15:0] ref_crc(input logic [7:0] msg[$], input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ msg[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic model_frame();
    st_t s;
    int  n;
    n = frm.size();
    if (n < 3) begin
      m_err++;
      s = '{ok: 1'b0, sh: 1'b1, len: 16'd0, rx: 16'h0000, calc: 16'hFFFF,
            okc: 16'(m_ok), errc: 16'(m_err)};
    end else begin
      for (int i = 0; i < n - 2; i++) exp_pay.push_back('{d: frm[i], last: (i == n - 3)});
      s.rx   = {frm[n-2], frm[n-1]};
      s.calc = ref_crc(frm, n - 2);
      s.ok   = (s.rx == s.calc);
      s.sh   = 1'b0;
      s.len  = 16'(n - 2);
      if (s.ok) m_ok++; else m_err++;
      s.okc  = 16'(m_ok);
      s.errc = 16'(m_err);
    end
    exp_st.push_back(s);
  endtask

  task automatic build_frame(input int plen, input bit corrupt);
    logic [15:0] c;
    frm.delete();
    for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
    c = ref_crc(frm, plen);
    if (corrupt) c = c ^ (16'h1 << $urandom_range(0, 15));
    frm.push_back(c[15:8]);
    frm.push_back(c[7:0]);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit acc;
    int k;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    k = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 1000);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input int gap_pct);
    model_frame();
    for (int i = 0; i < frm.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_byte(frm[i], i == frm.size() - 1);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_status_valid"}, 32'(status_valid), 32'd0);
    chk({tag, "_status_len"}, 32'(status_len), 32'd0);
    chk({tag, "_status_calc"}, 32'(status_crc_calc), 32'd0);
    chk({tag, "_ok_count"}, 32'(ok_count), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin : mon
    pay_t p;
    st_t  s;
    if (!rst) begin
      chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_pay.size() == 0) chk("payload_extra", 32'(out_valid), 32'd0);
        else begin
          p = exp_pay.pop_front();
          chk("out_data", 32'(out_data), 32'(p.d));
          chk("out_last", 32'(out_last), 32'(p.last));
        end
      end
      if (status_valid) begin
        if (exp_st.size() == 0) chk("status_extra", 32'(status_valid), 32'd0);
        else begin
          s = exp_st.pop_front();
          chk("st_crc_ok", 32'(status_crc_ok), 32'(s.ok));
          chk("st_short", 32'(status_short), 32'(s.sh));
          chk("st_len", 32'(status_len), 32'(s.len));
          chk("st_crc_rx", 32'(status_crc_rx), 32'(s.rx));
          chk("st_crc_calc", 32'(status_crc_calc), 32'(s.calc));
          chk("ok_count", 32'(ok_count), 32'(s.okc));
          chk("err_count", 32'(err_count), 32'(s.errc));
        end
      end
    end
  end

  initial begin
    logic [7:0] s9[$];
    int         k;
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    idle(2);

    // Check value "123456789" with its correct CRC.
    frm = s9; frm.push_back(8'h29); frm.push_back(8'hB1);
    send_frame(0);
    idle(3);
    chk("tp1_calc", 32'(status_crc_calc), 32'h29B1);
    chk("tp1_ok_count", 32'(ok_count), 32'd1);

    frm = '{8'h31, 8'hC7, 8'h82};
    send_frame(0);
    idle(3);
    chk("tp2_calc", 32'(status_crc_calc), 32'hC782);
    chk("tp2_len", 32'(status_len), 32'd1);

    frm = s9; frm.push_back(8'h29); frm.push_back(8'hB0);
    send_frame(0);
    idle(3);
    chk("tp3_rx", 32'(status_crc_rx), 32'h29B0);
    chk("tp3_err_count", 32'(err_count), 32'd1);

    frm = '{8'hAA, 8'hBB};
    send_frame(0);
    frm = '{8'h5A};
    send_frame(0);
    idle(3);
    chk("short_flag", 32'(status_short), 32'd1);

    // Back-to-back frames with throttled downstream.
    rdy_mode = 1'b1;
    build_frame(7, 1'b0);
    send_frame(0);
    build_frame(12, 1'b0);
    send_frame(0);
    idle(30);
    rdy_mode = 1'b0;
    idle(5);

    // Reset five bytes into a frame; only the bytes already forwarded are expected.
    build_frame(10, 1'b0);
    for (int i = 0; i < 3; i++) exp_pay.push_back('{d: frm[i], last: 1'b0});
    for (int i = 0; i < 5; i++) send_byte(frm[i], 1'b0);
    idle(3);
    chk("abort_drained", 32'(exp_pay.size()), 32'd0);
    rst = 1'b1;
    m_ok  = 0;
    m_err = 0;
    idle(2);
    check_reset("midreset");
    rst = 1'b0;
    idle(2);
    build_frame(6, 1'b0);
    send_frame(0);
    idle(3);
    chk("post_reset_ok", 32'(status_crc_ok), 32'd1);

    for (int f = 0; f < 30; f++) begin
      rdy_mode = ($urandom_range(0, 1) == 1);
      build_frame($urandom_range(0, 24), ($urandom_range(0, 3) == 0));
      send_frame(($urandom_range(0, 1) == 1) ? 20 : 0);
    end
    rdy_mode = 1'b0;
    idle(1);

    k = 0;
    while ((exp_pay.size() != 0 || exp_st.size() != 0) && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("pay_left", 32'(exp_pay.size()), 32'd0);
    chk("status_left", 32'(exp_st.size()), 32'd0);
    chk("ok_count_final", 32'(ok_count), 32'(m_ok));
    chk("err_count_final", 32'(err_count), 32'(m_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
